rtc_ad_bus_ctrl: RTL and testbench

RTC_AD_BUS_CTRL -- requirements
Module: rtc_ad_bus_ctrl

---
 rtl/rtc_bus_pkg.sv | 45 ++++
 rtl/rtc_ad_xfer.sv | 145 ++++++++++++++
 rtl/rtc_ad_bus_ctrl.sv | 141 ++++++++++++++
 tb/tb_rtc_ad_bus_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// -----------------------------------------------------------------------------
// rtc_bus_pkg
// Shared definitions for the RTC multiplexed address/data bus controller:
//   - state_t      : transaction sequencer state encoding
//   - DEF_T_STROBE : default strobe-low length (cycles)
//   - DEF_T_GAP    : default bus-release length (cycles)
//   - BUS_IDLE     : value driven on the AD bus when not driving (all-ones)
//   - phase_len()  : cycles spent in each sequencer state
// -----------------------------------------------------------------------------
package rtc_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_AD,
        ADDR_CS,
        ADDR_WR,
        ADDR_END,
        TURN,
        DATA_CS,
        DATA_STB,
        DATA_END,
        GAP
    } state_t;

    localparam int DEF_T_STROBE = 6;
    localparam int DEF_T_GAP    = 8;

    // Wide enough for any sensible bus width; users slice [DATA_W-1:0].
    localparam logic [63:0] BUS_IDLE = '1;

    // ADDR_END releases wr, cs, ad one per cycle; DATA_END releases the
    // strobe, then cs.
    function automatic int phase_len(state_t s, int t_strobe, int t_gap);
        int len;
        case (s)
            ADDR_WR, DATA_STB: len = t_strobe;
            TURN, GAP:         len = t_gap;
            ADDR_END:          len = 3;
            DATA_END:          len = 2;
            default:           len = 1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/rtc_ad_xfer.sv
// -----------------------------------------------------------------------------
// rtc_ad_xfer
// Single-transaction strobe sequencer for the RTC multiplexed AD bus.
// Runs one address phase, a bus turnaround, one data phase and a release gap.
// At the end of the gap it either chains straight into the next transaction
// (cont=1) or returns to IDLE.
//
// Ports:
//   clock, reset      : clock / asynchronous active-low reset
//   go                : start a transaction (honoured in IDLE only)
//   cont              : sampled at the end of GAP; 1 = chain another transaction
//   is_write          : current transaction is a write (stable after go)
//   addr, wdata       : address and write payload to drive
//   ad, cs, wr, rd    : active-low bus strobes
//   ADout, Pup        : bus drive value and read pull-up enable
//   idle              : sequencer is in IDLE
//   done              : last cycle of GAP (transaction complete)
//   sample            : last cycle of a read strobe; capture ADin on this edge
// -----------------------------------------------------------------------------
module rtc_ad_xfer
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int T_STROBE = DEF_T_STROBE,
    parameter int T_GAP    = DEF_T_GAP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              go,
    input  logic              cont,
    input  logic              is_write,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ad,
    output logic              cs,
    output logic              wr,
    output logic              rd,
    output logic [DATA_W-1:0] ADout,
    output logic              Pup,
    output logic              idle,
    output logic              done,
    output logic              sample
);

    localparam int T_MAX = (T_STROBE > T_GAP) ? T_STROBE : T_GAP;
    localparam int CNT_W = $clog2(T_MAX + 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             last;

    // Final cycle of the current phase.
    assign last   = (cnt == CNT_W'(phase_len(state, T_STROBE, T_GAP) - 1));
    assign idle   = (state == IDLE);
    assign done   = (state == GAP) && last;
    // rd returns high on the edge that ends DATA_STB, so ADin is captured there.
    assign sample = (state == DATA_STB) && last && !is_write;

    // NOTE: sequential state uses non-blocking (<=) so every register in the
    // design updates from the same pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_n = state;
        ad      = 1'b1;
        cs      = 1'b1;
        wr      = 1'b1;
        rd      = 1'b1;
        ADout   = BUS_IDLE[DATA_W-1:0];
        Pup     = 1'b0;

        unique case (state)
            IDLE: begin
                if (go) state_n = ADDR_AD;
            end
            ADDR_AD: begin
                ad = 1'b0;
                if (last) state_n = ADDR_CS;
            end
            ADDR_CS: begin
                ad = 1'b0;
                cs = 1'b0;
                if (last) state_n = ADDR_WR;
            end
            ADDR_WR: begin
                ad    = 1'b0;
                cs    = 1'b0;
                wr    = 1'b0;
                ADout = addr;
                if (last) state_n = ADDR_END;
            end
            ADDR_END: begin
                // Address held while the strobes release: wr, then cs, then ad.
                ADout = addr;
                cs    = (cnt != '0);
                ad    = (cnt == CNT_W'(2));
                if (last) state_n = TURN;
            end
            TURN: begin
                if (is_write) ADout = wdata;
                else          Pup   = 1'b1;
                if (last) state_n = DATA_CS;
            end
            DATA_CS: begin
                cs = 1'b0;
                if (is_write) ADout = wdata;
                if (last) state_n = DATA_STB;
            end
            DATA_STB: begin
                cs = 1'b0;
                if (is_write) begin
                    wr    = 1'b0;
                    ADout = wdata;
                end else begin
                    rd = 1'b0;
                end
                if (last) state_n = DATA_END;
            end
            DATA_END: begin
                cs = (cnt != '0);
                if (is_write) ADout = wdata;
                if (last) state_n = GAP;
            end
            GAP: begin
                if (last) state_n = cont ? ADDR_AD : IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Phase counter restarts on every state change and rests at 0 in IDLE.
        if (state_n != state || state == IDLE) cnt_n = '0;
        else                                   cnt_n = cnt + CNT_W'(1);
    end

endmodule

// File: rtl/rtc_ad_bus_ctrl.sv
// -----------------------------------------------------------------------------
// rtc_ad_bus_ctrl
// Bus master for an RTC on a multiplexed address/data bus. A rising edge on
// start reads NUM_REGS registers (addresses from addr_table) into regs_out;
// wr_req performs a single-register write. Writes win arbitration in IDLE but
// never interrupt a scan in progress.
//
// Ports:
//   clock, reset        : clock / asynchronous active-low reset
//   start               : level; rising edge requests one scan
//   addr_table          : scan addresses, entry i at [i*DATA_W +: DATA_W]
//   wr_req/addr/data    : write request (held until wr_ack), target, payload
//   wr_ack              : one-cycle pulse on write completion
//   ADin, ADout, Pup    : bus read data, bus drive value, read pull-up enable
//   ad, cs, wr, rd      : active-low bus strobes
//   regs_out            : last read value per entry, packed like addr_table
//   scan_done           : one-cycle pulse at the end of a scan
//   busy                : a transaction or scan is in progress
// -----------------------------------------------------------------------------
module rtc_ad_bus_ctrl
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 10,
    parameter int T_STROBE = DEF_T_STROBE,
    parameter int T_GAP    = DEF_T_GAP
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_REGS*DATA_W-1:0] addr_table,
    input  logic                       wr_req,
    input  logic [DATA_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ack,
    input  logic [DATA_W-1:0]          ADin,
    output logic [DATA_W-1:0]          ADout,
    output logic                       Pup,
    output logic                       ad,
    output logic                       cs,
    output logic                       wr,
    output logic                       rd,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       scan_done,
    output logic                       busy
);

    logic              start_q;
    logic              start_armed;
    logic              start_rise;
    logic              pending;
    logic              wr_mode;
    logic [3:0]        idx;
    logic              last_entry;
    logic              accept_wr;
    logic              accept_scan;
    logic              cont;
    logic [DATA_W-1:0] scan_addr;
    logic [DATA_W-1:0] xfer_addr;
    logic              xfer_idle;
    logic              xfer_done;
    logic              xfer_sample;

    // start_armed is only set once start has been seen low, so a level that
    // is already high when reset releases never counts as an edge.
    assign start_rise  = start && !start_q && start_armed;

    assign accept_wr   = xfer_idle && wr_req;
    assign accept_scan = xfer_idle && !wr_req && (pending || start_rise);
    assign last_entry  = (idx == 4'(NUM_REGS - 1));
    assign cont        = !wr_mode && !last_entry;

    assign busy        = !xfer_idle;
    assign wr_ack      = xfer_done && wr_mode;
    assign scan_done   = xfer_done && !wr_mode && last_entry;

    always_comb begin
        scan_addr = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 4'(i)) scan_addr = addr_table[i*DATA_W +: DATA_W];
        end
    end

    assign xfer_addr = wr_mode ? wr_addr : scan_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_q     <= 1'b0;
            start_armed <= 1'b0;
            pending     <= 1'b0;
            wr_mode     <= 1'b0;
            idx         <= '0;
            // NOTE: regs_out is a handful of flops, not a RAM, so it is reset
            // like any other state and reads back as zero after reset.
            regs_out    <= '0;
        end else begin
            start_q     <= start;
            start_armed <= start_armed || !start;

            // One pending scan at most; an edge coinciding with a scan
            // acceptance is absorbed by that scan.
            if (accept_scan)     pending <= 1'b0;
            else if (start_rise) pending <= 1'b1;

            if (accept_wr)        wr_mode <= 1'b1;
            else if (accept_scan) wr_mode <= 1'b0;

            if (xfer_done && !wr_mode) idx <= last_entry ? 4'd0 : idx + 4'd1;

            if (xfer_sample) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx == 4'(i)) regs_out[i*DATA_W +: DATA_W] <= ADin;
                end
            end
        end
    end

    rtc_ad_xfer #(
        .DATA_W   (DATA_W),
        .T_STROBE (T_STROBE),
        .T_GAP    (T_GAP)
    ) u_xfer (
        .clock    (clock),
        .reset    (reset),
        .go       (accept_wr || accept_scan),
        .cont     (cont),
        .is_write (wr_mode),
        .addr     (xfer_addr),
        .wdata    (wr_data),
        .ad       (ad),
        .cs       (cs),
        .wr       (wr),
        .rd       (rd),
        .ADout    (ADout),
        .Pup      (Pup),
        .idle     (xfer_idle),
        .done     (xfer_done),
        .sample   (xfer_sample)
    );

endmodule

// File: tb/tb_rtc_ad_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rtc_ad_bus_ctrl
// Directed bench for rtc_ad_bus_ctrl with NUM_REGS=3. A small RTC model latches
// the address written while ad is low and returns address+1 while rd is low.
// A bus monitor counts strobe pulses, their lengths and completion pulses.
// -----------------------------------------------------------------------------
module tb_rtc_ad_bus_ctrl;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 3;
    localparam int T_STROBE = 6;
    localparam int T_GAP    = 8;

    logic                       clock = 1'b0;
    logic                       reset = 1'b0;
    logic                       start = 1'b0;
    logic [NUM_REGS*DATA_W-1:0] addr_table = 24'hF02643;
    logic                       wr_req = 1'b0;
    logic [DATA_W-1:0]          wr_addr = '0;
    logic [DATA_W-1:0]          wr_data = '0;
    logic                       wr_ack;
    logic [DATA_W-1:0]          ADin;
    logic [DATA_W-1:0]          ADout;
    logic                       Pup;
    logic                       ad, cs, wr, rd;
    logic [NUM_REGS*DATA_W-1:0] regs_out;
    logic                       scan_done;
    logic                       busy;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    rtc_ad_bus_ctrl #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .T_STROBE (T_STROBE),
        .T_GAP    (T_GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .addr_table (addr_table),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .ADin       (ADin),
        .ADout      (ADout),
        .Pup        (Pup),
        .ad         (ad),
        .cs         (cs),
        .wr         (wr),
        .rd         (rd),
        .regs_out   (regs_out),
        .scan_done  (scan_done),
        .busy       (busy)
    );

    // RTC model: address latched while ad and wr are low; reads return addr+1.
    logic [DATA_W-1:0] rtc_addr = '0;
    always @(posedge clock) if (!ad && !wr) rtc_addr <= ADout;
    assign ADin = rd ? 8'hFF : rtc_addr + 8'd1;

    // Bus monitor, sampled on the falling edge.
    int rd_run = 0, rd_pulses = 0, rd_bad = 0;
    int wr_run = 0, wr_pulses = 0, wr_seg_bad = 0;
    int pup_cycles = 0, busy_cycles = 0, scan_done_cnt = 0, wr_ack_cnt = 0;
    logic [DATA_W-1:0] wr_seg_val [8];
    int                wr_seg_len [8];

    always @(negedge clock) begin
        if (!rd) rd_run++;
        else if (rd_run != 0) begin
            rd_pulses++;
            if (rd_run != T_STROBE) rd_bad++;
            rd_run = 0;
        end
        if (!wr) begin
            if (wr_run == 0) wr_seg_val[wr_pulses % 8] = ADout;
            else if (ADout !== wr_seg_val[wr_pulses % 8]) wr_seg_bad++;
            wr_run++;
        end else if (wr_run != 0) begin
            wr_seg_len[wr_pulses % 8] = wr_run;
            wr_pulses++;
            wr_run = 0;
        end
        if (Pup)       pup_cycles++;
        if (busy)      busy_cycles++;
        if (scan_done) scan_done_cnt++;
        if (wr_ack)    wr_ack_cnt++;
    end

    // Step to just after the falling edge: outputs settled, monitor updated.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if ({ad, cs, wr, rd, Pup} !== 5'b11110) begin
            failures++;
            $display("FAIL reset_strobes: got %b expected 11110", {ad, cs, wr, rd, Pup});
        end
        checks++;
        if (ADout !== 8'hFF) begin
            failures++;
            $display("FAIL reset_adout: got %h expected ff", ADout);
        end
        checks++;
        if ({busy, scan_done, wr_ack} !== 3'b000 || regs_out !== 24'h0) begin
            failures++;
            $display("FAIL reset_status: got busy/done/ack=%b regs=%h expected 000 000000",
                     {busy, scan_done, wr_ack}, regs_out);
        end
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_scan();
        int sd0 = scan_done_cnt, r0 = rd_pulses, rb0 = rd_bad, w0 = wr_pulses, a0 = wr_ack_cnt;
        bit ok = 0;
        addr_table = 24'hF02643;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (scan_done_cnt != sd0) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL scan_timeout: got no scan_done expected one within 400 cycles");
        end
        repeat (5) tick();
        checks++;
        if (regs_out !== 24'hF12744) begin
            failures++;
            $display("FAIL scan_regs: got %h expected f12744", regs_out);
        end
        checks++;
        if (scan_done_cnt - sd0 != 1) begin
            failures++;
            $display("FAIL scan_done_count: got %0d expected 1", scan_done_cnt - sd0);
        end
        checks++;
        if (rd_pulses - r0 != 3 || rd_bad != rb0) begin
            failures++;
            $display("FAIL scan_rd_pulses: got %0d pulses %0d wrong length expected 3 and 0",
                     rd_pulses - r0, rd_bad - rb0);
        end
        checks++;
        if (wr_pulses - w0 != 3 || wr_seg_val[w0 % 8] !== 8'h43 ||
            wr_seg_val[(w0 + 1) % 8] !== 8'h26 || wr_seg_val[(w0 + 2) % 8] !== 8'hF0) begin
            failures++;
            $display("FAIL scan_addresses: got %0d strobes %h %h %h expected 3 strobes 43 26 f0",
                     wr_pulses - w0, wr_seg_val[w0 % 8], wr_seg_val[(w0 + 1) % 8],
                     wr_seg_val[(w0 + 2) % 8]);
        end
        checks++;
        if (busy !== 1'b0 || wr_ack_cnt != a0) begin
            failures++;
            $display("FAIL scan_idle: got busy=%b acks=%0d expected 0 0", busy, wr_ack_cnt - a0);
        end
    endtask

    task automatic test_write();
        int a0 = wr_ack_cnt, w0 = wr_pulses, wb0 = wr_seg_bad, r0 = rd_pulses, p0 = pup_cycles;
        bit ok = 0;
        wr_addr = 8'h21;
        wr_data = 8'h59;
        wr_req  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (wr_ack === 1'b1) begin ok = 1; break; end
        end
        wr_req = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL write_timeout: got no wr_ack expected one within 200 cycles");
        end
        repeat (10) tick();
        checks++;
        if (wr_ack_cnt - a0 != 1) begin
            failures++;
            $display("FAIL write_ack_count: got %0d expected 1", wr_ack_cnt - a0);
        end
        checks++;
        if (wr_pulses - w0 != 2 || wr_seg_val[w0 % 8] !== 8'h21 ||
            wr_seg_val[(w0 + 1) % 8] !== 8'h59 || wr_seg_bad != wb0) begin
            failures++;
            $display("FAIL write_bus_values: got %0d strobes %h %h expected 2 strobes 21 59",
                     wr_pulses - w0, wr_seg_val[w0 % 8], wr_seg_val[(w0 + 1) % 8]);
        end
        checks++;
        if (wr_seg_len[w0 % 8] != T_STROBE || wr_seg_len[(w0 + 1) % 8] != T_STROBE) begin
            failures++;
            $display("FAIL write_strobe_len: got %0d %0d expected %0d %0d",
                     wr_seg_len[w0 % 8], wr_seg_len[(w0 + 1) % 8], T_STROBE, T_STROBE);
        end
        checks++;
        if (pup_cycles != p0 || rd_pulses != r0) begin
            failures++;
            $display("FAIL write_no_read: got pup_cycles=%0d rd_pulses=%0d expected 0 0",
                     pup_cycles - p0, rd_pulses - r0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL write_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_collide();
        int a0 = wr_ack_cnt, sd0 = scan_done_cnt;
        bit ok = 0;
        addr_table = 24'h302010;
        wr_addr = 8'h0A;
        wr_data = 8'h3C;
        wr_req  = 1'b1;
        start   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i == 2) start = 1'b0;
            if (wr_ack === 1'b1) begin ok = 1; break; end
        end
        wr_req = 1'b0;
        start  = 1'b0;
        checks++;
        if (!ok || scan_done_cnt != sd0) begin
            failures++;
            $display("FAIL collide_write_first: got ack=%0d scans=%0d expected ack before any scan",
                     ok, scan_done_cnt - sd0);
        end
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (scan_done_cnt != sd0) begin ok = 1; break; end
        end
        repeat (5) tick();
        checks++;
        if (!ok || scan_done_cnt - sd0 != 1 || wr_ack_cnt - a0 != 1) begin
            failures++;
            $display("FAIL collide_pulses: got scans=%0d acks=%0d expected 1 1",
                     scan_done_cnt - sd0, wr_ack_cnt - a0);
        end
        checks++;
        if (regs_out !== 24'h312111) begin
            failures++;
            $display("FAIL collide_regs: got %h expected 312111", regs_out);
        end
    endtask

    task automatic test_multi_start();
        int sd0 = scan_done_cnt, r0 = rd_pulses;
        bit ok = 0;
        addr_table = 24'hF02643;
        pulse_start();
        repeat (3) begin
            repeat (3) tick();
            pulse_start();
        end
        for (int i = 0; i < 600; i++) begin
            tick();
            if (scan_done_cnt - sd0 >= 2) begin ok = 1; break; end
        end
        repeat (60) tick();
        checks++;
        if (!ok || scan_done_cnt - sd0 != 2) begin
            failures++;
            $display("FAIL multi_scan_count: got %0d expected 2", scan_done_cnt - sd0);
        end
        checks++;
        if (rd_pulses - r0 != 6) begin
            failures++;
            $display("FAIL multi_rd_pulses: got %0d expected 6", rd_pulses - r0);
        end
        checks++;
        if (busy !== 1'b0 || regs_out !== 24'hF12744) begin
            failures++;
            $display("FAIL multi_final: got busy=%b regs=%h expected 0 f12744", busy, regs_out);
        end
    endtask

    task automatic test_reset_mid_scan();
        int r0 = rd_pulses, b0, rp0;
        bit ok = 0;
        addr_table = 24'hF02643;
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rd_pulses - r0 == 1 && rd === 1'b0) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL midreset_reach: got no second rd strobe expected one within 200 cycles");
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({ad, cs, wr, rd, Pup, busy} !== 6'b111100 || ADout !== 8'hFF) begin
            failures++;
            $display("FAIL midreset_outputs: got %b adout=%h expected 111100 ff",
                     {ad, cs, wr, rd, Pup, busy}, ADout);
        end
        checks++;
        if (regs_out !== 24'h0) begin
            failures++;
            $display("FAIL midreset_regs: got %h expected 000000", regs_out);
        end
        start = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        b0  = busy_cycles;
        rp0 = rd_pulses;
        repeat (60) tick();
        checks++;
        if (busy_cycles != b0 || rd_pulses != rp0 || regs_out !== 24'h0) begin
            failures++;
            $display("FAIL midreset_no_scan: got busy_cycles=%0d rd=%0d regs=%h expected 0 0 000000",
                     busy_cycles - b0, rd_pulses - rp0, regs_out);
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write();
        test_collide();
        test_multi_start();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
